// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the combinational program ROM and
// registers the returned word with its address for decode.
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module instr_fetch #(
   parameter int ADDR_BITS = `ADDR_BITS,
   parameter int DATA_BITS = `DATA_BITS,
   parameter logic [ADDR_BITS-1:0] START_ADDR = '0,
   parameter logic [2*DATA_BITS-1:0] HALT_WORD = '1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   branch_valid,
   input  logic [ADDR_BITS-1:0]   branch_target,
   output logic [ADDR_BITS-1:0]   rom_addr,
   input  logic [2*DATA_BITS-1:0] rom_data,
   output logic [2*DATA_BITS-1:0] instr,
   output logic [ADDR_BITS-1:0]   instr_pc,
   output logic                   instr_valid,
   output logic                   halted
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e                 state_q;
   logic [ADDR_BITS-1:0]   pc_q;
   logic [2*DATA_BITS-1:0] instr_q;
   logic [ADDR_BITS-1:0]   instr_pc_q;
   logic                   valid_q;
   logic [ADDR_BITS-1:0]   pc_inc_d;
   logic                   is_halt_d;

   assign pc_inc_d  = pc_q + 1'b1;
   assign is_halt_d = (rom_data == HALT_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= START_ADDR;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  pc_q    <= START_ADDR;
               end
            end
            RUN: begin
               // Redirect beats stall so a taken branch is never lost.
               if (branch_valid) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
               end else if (!stall) begin
                  instr_q    <= rom_data;
                  instr_pc_q <= pc_q;
                  valid_q    <= 1'b1;
                  if (is_halt_d) begin
                     state_q <= HALTED;
                  end else begin
                     pc_q <= pc_inc_d;
                  end
               end
            end
            HALTED: begin
               if (start) begin
                  state_q <= RUN;
                  pc_q    <= START_ADDR;
                  valid_q <= 1'b0;
               end else if (!stall) begin
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign rom_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetches are queued as
// stimulus is driven and compared against the registered outputs.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        branch_valid;
   logic [7:0]  branch_target;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        halted;

   int checks;
   int failures;

   typedef struct {
      logic        v;
      logic [7:0]  pc;
      logic [31:0] w;
      logic [7:0]  ra;
      logic        h;
   } exp_t;

   exp_t sb[$];

   function automatic logic [31:0] rom_word(input logic [7:0] a);
      if (a == 8'd5) return 32'hFFFF_FFFF;
      return 32'h1000_0000 + {24'h0, a};
   endfunction

   assign rom_data = rom_word(rom_addr);

   instr_fetch #(
      .ADDR_BITS(8),
      .DATA_BITS(16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stall        (stall),
      .branch_valid (branch_valid),
      .branch_target(branch_target),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic v, input logic [7:0] pc,
                               input logic [31:0] w, input logic [7:0] ra,
                               input logic h);
      exp_t e;
      e.v = v; e.pc = pc; e.w = w; e.ra = ra; e.h = h;
      return e;
   endfunction

   task automatic reset_start();
      rst_n = 1'b0; start = 1'b0; stall = 1'b0;
      branch_valid = 1'b0; branch_target = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stall = 1'b0;
      branch_valid = 1'b0; branch_target = 8'h00;
      #1;
      checks++;
      if (instr !== 32'h0 || instr_pc !== 8'h0 || instr_valid !== 1'b0
          || halted !== 1'b0 || rom_addr !== 8'h0) begin
         failures++;
         $display("FAIL reset: instr=%h pc=%h v=%b h=%b ra=%h exp 0/0/0/0/0",
                  instr, instr_pc, instr_valid, halted, rom_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      branch_valid = 1'b1; branch_target = 8'h40; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (rom_addr !== 8'h00 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore[%0d]: ra=%h v=%b h=%b exp 00/0/0",
                     i, rom_addr, instr_valid, halted);
         end
      end
      branch_valid = 1'b0; stall = 1'b0;
   endtask

   task automatic test_sequential();
      exp_t e;
      reset_start();
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
         failures++;
         $display("FAIL seq_first: v=%b ra=%h exp 0/00", instr_valid, rom_addr);
      end
      for (int a = 0; a < 5; a++)
         sb.push_back(mk(1'b1, 8'(a), rom_word(8'(a)), 8'(a + 1), 1'b0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (instr_valid !== e.v || instr_pc !== e.pc || instr !== e.w
             || rom_addr !== e.ra) begin
            failures++;
            $display("FAIL seq pc: got v=%b pc=%h w=%h ra=%h exp %b/%h/%h/%h",
                     instr_valid, instr_pc, instr, rom_addr,
                     e.v, e.pc, e.w, e.ra);
         end
      end
   endtask

   task automatic test_stall_branch();
      exp_t e;
      reset_start();
      sb.push_back(mk(1'b1, 8'h00, rom_word(8'h00), 8'h01, 1'b0));
      sb.push_back(mk(1'b1, 8'h01, rom_word(8'h01), 8'h02, 1'b0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (instr_pc !== e.pc || instr !== e.w || rom_addr !== e.ra) begin
            failures++;
            $display("FAIL pre_stall: pc=%h w=%h ra=%h exp %h/%h/%h",
                     instr_pc, instr, rom_addr, e.pc, e.w, e.ra);
         end
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++)
         sb.push_back(mk(1'b1, 8'h01, 32'h1000_0001, 8'h02, 1'b0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (instr_valid !== e.v || instr_pc !== e.pc || instr !== e.w
             || rom_addr !== e.ra) begin
            failures++;
            $display("FAIL stall_hold: v=%b pc=%h w=%h ra=%h exp %b/%h/%h/%h",
                     instr_valid, instr_pc, instr, rom_addr,
                     e.v, e.pc, e.w, e.ra);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_pc !== 8'h02 || instr !== 32'h1000_0002 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_release: pc=%h w=%h v=%b exp 02/10000002/1",
                  instr_pc, instr, instr_valid);
      end
      stall = 1'b1; branch_valid = 1'b1; branch_target = 8'h40;
      sb.push_back(mk(1'b0, 8'h00, 32'h0, 8'h40, 1'b0));
      sb.push_back(mk(1'b1, 8'h40, 32'h1000_0040, 8'h41, 1'b0));
      @(negedge clk);
      stall = 1'b0; branch_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (instr_valid !== e.v || rom_addr !== e.ra) begin
         failures++;
         $display("FAIL branch_flush: v=%b ra=%h exp %b/%h",
                  instr_valid, rom_addr, e.v, e.ra);
      end
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (instr_valid !== e.v || instr_pc !== e.pc || instr !== e.w
          || rom_addr !== e.ra) begin
         failures++;
         $display("FAIL branch_fetch: v=%b pc=%h w=%h ra=%h exp %b/%h/%h/%h",
                  instr_valid, instr_pc, instr, rom_addr, e.v, e.pc, e.w, e.ra);
      end
   endtask

   task automatic test_halt();
      exp_t e;
      reset_start();
      for (int a = 0; a < 5; a++)
         sb.push_back(mk(1'b1, 8'(a), rom_word(8'(a)), 8'(a + 1), 1'b0));
      sb.push_back(mk(1'b1, 8'h05, 32'hFFFF_FFFF, 8'h05, 1'b1));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (instr_valid !== e.v || instr_pc !== e.pc || instr !== e.w
             || rom_addr !== e.ra || halted !== e.h) begin
            failures++;
            $display("FAIL halt_run: v=%b pc=%h w=%h ra=%h h=%b exp %b/%h/%h/%h/%b",
                     instr_valid, instr_pc, instr, rom_addr, halted,
                     e.v, e.pc, e.w, e.ra, e.h);
         end
      end
      stall = 1'b1;
      sb.push_back(mk(1'b1, 8'h05, 32'hFFFF_FFFF, 8'h05, 1'b1));
      sb.push_back(mk(1'b0, 8'h05, 32'hFFFF_FFFF, 8'h05, 1'b1));
      sb.push_back(mk(1'b0, 8'h05, 32'hFFFF_FFFF, 8'h05, 1'b1));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stall = 1'b0;
         if (i == 1) begin
            branch_valid = 1'b1; branch_target = 8'h40;
         end else begin
            branch_valid = 1'b0;
         end
         e = sb.pop_front();
         checks++;
         if (instr_valid !== e.v || rom_addr !== e.ra || halted !== e.h
             || instr !== e.w) begin
            failures++;
            $display("FAIL halted[%0d]: v=%b ra=%h h=%b w=%h exp %b/%h/%b/%h",
                     i, instr_valid, rom_addr, halted, instr,
                     e.v, e.ra, e.h, e.w);
         end
      end
      start = 1'b1; branch_valid = 1'b1; branch_target = 8'h40;
      @(negedge clk);
      start = 1'b0; branch_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || rom_addr !== 8'h00 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL restart: h=%b ra=%h v=%b exp 0/00/0",
                  halted, rom_addr, instr_valid);
      end
      @(negedge clk);
      checks++;
      if (instr_pc !== 8'h00 || instr !== 32'h1000_0000 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL restart_fetch: pc=%h w=%h v=%b exp 00/10000000/1",
                  instr_pc, instr, instr_valid);
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      reset_start();
      branch_valid = 1'b1; branch_target = 8'hFE;
      @(negedge clk);
      branch_valid = 1'b0;
      checks++;
      if (rom_addr !== 8'hFE || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_branch: ra=%h v=%b exp fe/0", rom_addr, instr_valid);
      end
      sb.push_back(mk(1'b1, 8'hFE, rom_word(8'hFE), 8'hFF, 1'b0));
      sb.push_back(mk(1'b1, 8'hFF, rom_word(8'hFF), 8'h00, 1'b0));
      sb.push_back(mk(1'b1, 8'h00, rom_word(8'h00), 8'h01, 1'b0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (instr_valid !== e.v || instr_pc !== e.pc || instr !== e.w
             || rom_addr !== e.ra) begin
            failures++;
            $display("FAIL wrap: v=%b pc=%h w=%h ra=%h exp %b/%h/%h/%h",
                     instr_valid, instr_pc, instr, rom_addr,
                     e.v, e.pc, e.w, e.ra);
         end
      end
   endtask

   task automatic test_async_reset();
      reset_start();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (instr !== 32'h0 || instr_pc !== 8'h0 || instr_valid !== 1'b0
          || halted !== 1'b0 || rom_addr !== 8'h0) begin
         failures++;
         $display("FAIL async_reset: instr=%h pc=%h v=%b h=%b ra=%h exp 0",
                  instr, instr_pc, instr_valid, halted, rom_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_idle[%0d]: v=%b ra=%h exp 0/00",
                     i, instr_valid, rom_addr);
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 32'h1000_0000) begin
         failures++;
         $display("FAIL post_reset_start: v=%b pc=%h w=%h exp 1/00/10000000",
                  instr_valid, instr_pc, instr);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_sequential();
      test_stall_branch();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Sequential fetch initiator on the read side of the combinational program ROM.
- Owns the program counter, drives the ROM address, and captures the returned 2*DATA_BITS-wide word into a registered instruction slot for decode.
- Supports stall, branch redirect (with flush), start, and halt-on-sentinel.
- Sits between the ROM and the decode/execute stage of the processor.

Parameters:
ADDR_BITS, `ADDR_BITS (from defines.sv), width of PC / ROM address
DATA_BITS, `DATA_BITS (from defines.sv), instruction word is 2*DATA_BITS wide
START_ADDR, 0, PC value loaded on reset and on start
HALT_WORD, all-ones (2*DATA_BITS), sentinel instruction that halts fetch

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins fetching at START_ADDR from IDLE or HALTED
stall  input  1  downstream not ready; hold PC and instruction slot
branch_valid  input  1  redirect request
branch_target  input  ADDR_BITS  redirect PC
rom_addr  output  ADDR_BITS  ROM read address, combinational = pc
rom_data  input  2*DATA_BITS  ROM read data, valid in the same cycle as rom_addr
instr  output  2*DATA_BITS  registered fetched word
instr_pc  output  ADDR_BITS  address instr was fetched from
instr_valid  output  1  instr is a live instruction
halted  output  1  high while in HALTED

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=START_ADDR, instr=0, instr_pc=0, instr_valid=0, halted=0.
  - Takes effect immediately mid-operation; no partial fetch survives.
- States: IDLE, RUN, HALTED. All transitions occur on rising clk.
- IDLE:
  - rom_addr=pc; instr_valid stays 0.
  - start=1 -> RUN, pc<=START_ADDR.
  - branch_valid and stall are ignored.
- RUN, priority order per cycle:
  1. branch_valid=1 (wins over stall): pc<=branch_target, instr_valid<=0 (flush); instr and instr_pc are don't-care but held.
  2. stall=1: pc, instr, instr_pc, instr_valid all held.
  3. Otherwise: instr<=rom_data, instr_pc<=pc, instr_valid<=1.
     - If rom_data==HALT_WORD: pc held, state<=HALTED.
     - Else pc<=pc+1, modulo 2^ADDR_BITS; wraps max -> 0 silently.
- Latency: one cycle from pc presented on rom_addr to instr/instr_valid updated. Throughput is one instruction per unstalled cycle.
- HALTED:
  - halted=1; the halt word remains in instr with instr_valid=1 until the first cycle with stall=0, then instr_valid<=0.
  - pc frozen; branch_valid ignored.
  - start=1 -> RUN, pc<=START_ADDR, instr_valid<=0.
- start in RUN is ignored.
- start and branch_valid together in IDLE/HALTED: start wins; branch is ignored.
- halted is a decode of state; it is 1 in the cycle after the halt word is captured.
- rom_addr never goes X after reset; it always equals pc.

Test Plan:
Bench configuration: ADDR_BITS=8, DATA_BITS=16, ROM model word[a]=32'h1000_0000+a, word[5]=32'hFFFF_FFFF.
- Reset then start pulse, no stall -> instr_pc sequence 0,1,2,3,4 with instr 32'h1000_0000..32'h1000_0004, instr_valid=1 from cycle 2 after start.
- Stall held 3 cycles at pc=2 -> instr=32'h1000_0001, instr_pc=1, rom_addr=2 constant for 3 cycles; on release the next instr_pc is 2.
- Branch to 8'h40 coincident with stall -> next cycle instr_valid=0, rom_addr=8'h40; following cycle instr_pc=8'h40, instr=32'h1000_0040.
- Fetch reaches addr 5 -> instr=32'hFFFF_FFFF, instr_valid=1, then halted=1 and rom_addr stays 5. With stall=0, instr_valid=0 one cycle later; a branch in HALTED has no effect; start restarts at pc=0.
- Branch to 8'hFE, run unstalled -> instr_pc 8'hFE, 8'hFF, 8'h00 (wrap).
- rst_n asserted mid-RUN between clock edges -> outputs drop to reset values immediately; after release, state=IDLE and instr_valid stays 0 until start.
